// File: rtl/wb_regfile_pkg.sv
// Shared write-back definitions: datapath sizing, control-bundle bit positions
// and the write-back source select used by the pipeline and the regfile.
package wb_regfile_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    localparam int CTL_REG_WRITE  = 0;
    localparam int CTL_MEM_TO_REG = 1;
    localparam int CTL_OUT_WRITE  = 2;

    typedef logic [2:0] wb_ctl_t;

    function automatic logic [DATA_W-1:0] wb_select(
        input wb_ctl_t           ctl,
        input logic [DATA_W-1:0] alu_data,
        input logic [DATA_W-1:0] mem_data
    );
        logic [DATA_W-1:0] sel;
        if (ctl[CTL_MEM_TO_REG]) begin
            sel = mem_data;
        end else begin
            sel = alu_data;
        end
        return sel;
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Bundle and read-port signals between the MEM/WB buffer, decode stage and
// the write-back register file.
interface wb_regfile_if
    import wb_regfile_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
);
    wb_ctl_t         controlSignals_in;
    logic [DW-1:0]   alu_data_in;
    logic [DW-1:0]   mem_data_in;
    logic [AW-1:0]   write_add_in;
    logic [AW-1:0]   read_add1;
    logic [AW-1:0]   read_add2;
    logic [DW-1:0]   read_data1;
    logic [DW-1:0]   read_data2;
    logic [DW-1:0]   wb_data_out;
    logic            wb_valid_out;
    logic [DW-1:0]   out_port;
    logic [15:0]     retired_count;

    modport master (
        output controlSignals_in, alu_data_in, mem_data_in, write_add_in,
               read_add1, read_add2,
        input  read_data1, read_data2, wb_data_out, wb_valid_out,
               out_port, retired_count
    );

    modport slave (
        input  controlSignals_in, alu_data_in, mem_data_in, write_add_in,
               read_add1, read_add2,
        output read_data1, read_data2, wb_data_out, wb_valid_out,
               out_port, retired_count
    );
endinterface

// File: rtl/wb_regfile_regfile_core.sv
// Architectural register array: one synchronous write port and two
// combinational read ports that forward the in-flight write value.
module regfile_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);
    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Next array contents: only the addressed entry changes on a write.
    always_comb begin
        regs_d = regs_q;
        if (we_i) begin
            regs_d[waddr_i] = wdata_i;
        end else begin
            regs_d = regs_q;
        end
    end

    // Array storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports; we_i is already gated by reset, so bypass drops out in reset.
    always_comb begin
        if (we_i && (raddr1_i == waddr_i)) begin
            rdata1_o = wdata_i;
        end else begin
            rdata1_o = regs_q[raddr1_i];
        end
        if (we_i && (raddr2_i == waddr_i)) begin
            rdata2_o = wdata_i;
        end else begin
            rdata2_o = regs_q[raddr2_i];
        end
    end
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: picks the commit value, updates the register file,
// the output port and the retired-bundle counter.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    wb_regfile_if.slave   bus
);
    wb_ctl_t           ctl_s;
    logic [DATA_W-1:0] wb_data_s;
    logic              reg_write_s;
    logic              retire_s;
    logic [DATA_W-1:0] out_port_q;
    logic [DATA_W-1:0] out_port_d;
    logic [15:0]       retired_count_q;
    logic [15:0]       retired_count_d;

    assign ctl_s       = bus.controlSignals_in;
    assign wb_data_s   = wb_select(ctl_s, bus.alu_data_in, bus.mem_data_in);
    assign reg_write_s = ctl_s[CTL_REG_WRITE] & ~rst;
    assign retire_s    = ctl_s[CTL_REG_WRITE] | ctl_s[CTL_OUT_WRITE];

    regfile_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .we_i     (reg_write_s),
        .waddr_i  (bus.write_add_in),
        .wdata_i  (wb_data_s),
        .raddr1_i (bus.read_add1),
        .raddr2_i (bus.read_add2),
        .rdata1_o (bus.read_data1),
        .rdata2_o (bus.read_data2)
    );

    // Next output-port value and retired count; a mem_to_reg-only bundle does not retire.
    always_comb begin
        out_port_d      = out_port_q;
        retired_count_d = retired_count_q;
        if (ctl_s[CTL_OUT_WRITE]) begin
            out_port_d = wb_data_s;
        end else begin
            out_port_d = out_port_q;
        end
        if (retire_s) begin
            retired_count_d = retired_count_q + 16'd1;
        end else begin
            retired_count_d = retired_count_q;
        end
    end

    // Output port and counter registers; reset wins over a same-cycle bundle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_port_q      <= '0;
            retired_count_q <= 16'd0;
        end else begin
            out_port_q      <= out_port_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign bus.wb_data_out   = wb_data_s;
    assign bus.wb_valid_out  = reg_write_s;
    assign bus.out_port      = out_port_q;
    assign bus.retired_count = retired_count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed bundles push their hand-computed
// expectations; a negedge monitor pops and compares every cycle.
module tb_wb_regfile;
    logic clk;
    logic rst;

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] wbd;
        logic        wbv;
        logic [15:0] outp;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input string field,
                       input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%04h expected 0x%04h", name, field, act, exp);
        end
    endtask

    // Monitor: compare the DUT against the expectation for this cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk(e.name, "read_data1",    bus.read_data1,            e.rd1);
            chk(e.name, "read_data2",    bus.read_data2,            e.rd2);
            chk(e.name, "wb_data_out",   bus.wb_data_out,           e.wbd);
            chk(e.name, "wb_valid_out",  {15'd0, bus.wb_valid_out}, {15'd0, e.wbv});
            chk(e.name, "out_port",      bus.out_port,              e.outp);
            chk(e.name, "retired_count", bus.retired_count,         e.cnt);
        end
    end

    task automatic row(input string name, input logic r, input logic [2:0] ctl,
                       input logic [15:0] alu, input logic [15:0] mem,
                       input logic [2:0] wa, input logic [2:0] ra1, input logic [2:0] ra2,
                       input logic [15:0] e_rd1, input logic [15:0] e_rd2,
                       input logic [15:0] e_wbd, input logic e_wbv,
                       input logic [15:0] e_out, input logic [15:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst                   = r;
        bus.controlSignals_in = ctl;
        bus.alu_data_in       = alu;
        bus.mem_data_in       = mem;
        bus.write_add_in      = wa;
        bus.read_add1         = ra1;
        bus.read_add2         = ra2;
        e.name = name;
        e.rd1  = e_rd1;
        e.rd2  = e_rd2;
        e.wbd  = e_wbd;
        e.wbv  = e_wbv;
        e.outp = e_out;
        e.cnt  = e_cnt;
        sb_q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] i16;
        rst                   = 1'b1;
        bus.controlSignals_in = 3'b000;
        bus.alu_data_in       = 16'h0000;
        bus.mem_data_in       = 16'h0000;
        bus.write_add_in      = 3'd0;
        bus.read_add1         = 3'd0;
        bus.read_add2         = 3'd0;
        repeat (2) @(posedge clk);

        //   name          rst ctl     alu       mem       wa  ra1 ra2  rd1       rd2       wbd       wbv   out       cnt
        row("reset_state", 1'b1, 3'b001, 16'h7777, 16'h0000, 3'd1, 3'd1, 3'd4, 16'h0000, 16'h0000, 16'h7777, 1'b0, 16'h0000, 16'h0000);
        row("bypass_w5",   1'b0, 3'b001, 16'h1234, 16'h0000, 3'd5, 3'd5, 3'd0, 16'h1234, 16'h0000, 16'h1234, 1'b1, 16'h0000, 16'h0000);
        row("array_r5",    1'b0, 3'b000, 16'h9999, 16'h0000, 3'd5, 3'd5, 3'd5, 16'h1234, 16'h1234, 16'h9999, 1'b0, 16'h0000, 16'h0001);
        row("memload_r2",  1'b0, 3'b011, 16'hAAAA, 16'h5555, 3'd2, 3'd2, 3'd5, 16'h5555, 16'h1234, 16'h5555, 1'b1, 16'h0000, 16'h0001);
        row("array_r2",    1'b0, 3'b000, 16'h0000, 16'h0000, 3'd0, 3'd2, 3'd2, 16'h5555, 16'h5555, 16'h0000, 1'b0, 16'h0000, 16'h0002);
        row("out_write",   1'b0, 3'b100, 16'h00FF, 16'h1111, 3'd5, 3'd5, 3'd2, 16'h1234, 16'h5555, 16'h00FF, 1'b0, 16'h0000, 16'h0002);
        row("idle_1",      1'b0, 3'b000, 16'h0000, 16'h0000, 3'd5, 3'd5, 3'd2, 16'h1234, 16'h5555, 16'h0000, 1'b0, 16'h00FF, 16'h0003);
        row("idle_2",      1'b0, 3'b000, 16'h0000, 16'h0000, 3'd5, 3'd5, 3'd2, 16'h1234, 16'h5555, 16'h0000, 1'b0, 16'h00FF, 16'h0003);
        row("idle_3",      1'b0, 3'b000, 16'h0000, 16'h0000, 3'd5, 3'd5, 3'd2, 16'h1234, 16'h5555, 16'h0000, 1'b0, 16'h00FF, 16'h0003);
        row("m2r_only",    1'b0, 3'b010, 16'h0000, 16'hCAFE, 3'd5, 3'd5, 3'd2, 16'h1234, 16'h5555, 16'hCAFE, 1'b0, 16'h00FF, 16'h0003);
        row("preload_r3",  1'b0, 3'b101, 16'h0001, 16'h0000, 3'd3, 3'd3, 3'd3, 16'h0001, 16'h0001, 16'h0001, 1'b1, 16'h00FF, 16'h0003);
        row("rst_cycle",   1'b1, 3'b101, 16'hBEEF, 16'h0000, 3'd3, 3'd3, 3'd0, 16'h0001, 16'h0000, 16'hBEEF, 1'b0, 16'h0001, 16'h0004);
        row("after_rst",   1'b0, 3'b000, 16'h0000, 16'h0000, 3'd3, 3'd3, 3'd5, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        row("write_r0",    1'b0, 3'b001, 16'h0042, 16'h0000, 3'd0, 3'd0, 3'd7, 16'h0042, 16'h0000, 16'h0042, 1'b1, 16'h0000, 16'h0000);
        row("array_r0",    1'b0, 3'b000, 16'h0000, 16'h0000, 3'd0, 3'd0, 3'd0, 16'h0042, 16'h0042, 16'h0000, 1'b0, 16'h0000, 16'h0001);

        // 65535 retiring writes starting from count 1 bring the counter round to 0.
        for (int i = 0; i < 65535; i++) begin
            i16 = 16'(i);
            row("wrap", 1'b0, 3'b001, i16, 16'h0000, i16[2:0], i16[2:0], i16[2:0],
                i16, i16, i16, 1'b1, 16'h0000, 16'(i + 1));
        end

        row("wrapped",     1'b0, 3'b000, 16'h0000, 16'h0000, 3'd0, 3'd7, 3'd7, 16'hFFF7, 16'hFFF7, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        row("post_wrap",   1'b0, 3'b001, 16'h0BAD, 16'h0000, 3'd1, 3'd1, 3'd6, 16'h0BAD, 16'hFFFE, 16'h0BAD, 1'b1, 16'h0000, 16'h0000);
        row("count_1",     1'b0, 3'b000, 16'h0000, 16'h0000, 3'd0, 3'd1, 3'd1, 16'h0BAD, 16'h0BAD, 16'h0000, 1'b0, 16'h0000, 16'h0001);

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file that consumes the bundle launched by the memory/write-back pipeline buffer. Selects the write-back value (ALU result or memory data), commits it to an 8-entry register file, and drives the output-port register. Serves the decode stage through two combinational read ports with same-cycle write-through bypass, and exposes a retired-instruction counter for debug.

## Interface
- DATA_W, 16, datapath and register width
- ADDR_W, 3, register address width (2^ADDR_W registers)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- controlSignals_in  in  3  [0] reg_write, [1] mem_to_reg, [2] out_write; all-zero means flushed bubble
- alu_data_in  in  DATA_W  ALU result from the buffer
- mem_data_in  in  DATA_W  memory load data from the buffer
- write_add_in  in  ADDR_W  destination register
- read_add1, read_add2  in  ADDR_W  decode-stage read addresses
- read_data1, read_data2  out  DATA_W  read port data (combinational)
- wb_data_out  out  DATA_W  selected write-back value (combinational, for forwarding)
- wb_valid_out  out  1  reg_write asserted this cycle (combinational)
- out_port  out  DATA_W  registered output port
- retired_count  out  16  registered count of retired non-bubble bundles

## Operation
- wb_data = mem_to_reg ? mem_data_in : alu_data_in; driven to wb_data_out every cycle regardless of reg_write.
- wb_valid_out = reg_write && !rst.
- Commit on rising clk when !rst:
  - reg_write=1: regs[write_add_in] <= wb_data. All registers, including r0, are writable.
  - out_write=1: out_port <= wb_data.
  - reg_write and out_write may both be set; both commit the same value.
  - reg_write=1 or out_write=1: retired_count <= retired_count + 1, wraps 0xFFFF -> 0x0000.
  - controlSignals_in = 3'b000: no state change. mem_to_reg alone does not count as retired.
- Reads: read_dataN = (reg_write && !rst && read_addN == write_add_in) ? wb_data : regs[read_addN]. Both ports may address the same register; both receive identical data.
- Reset, on rising clk with rst=1: all registers, out_port and retired_count go to 0. Reset dominates any same-cycle write, out_write or count. Bypass is suppressed while rst=1; reads return stored contents.
- Reset mid-stream: a bundle present in the reset cycle is discarded. The first bundle after rst deasserts commits normally.

## Timing
- Write-to-read latency is 0 cycles via bypass. The stored value is visible through the array one cycle after the commit edge.
- out_port and retired_count update one cycle after the bundle is presented.
- No handshake. A bundle is valid for exactly the one cycle it is presented; the upstream buffer guarantees stability across the edge.
- Reset values: read_data* = 0 after the reset edge, wb_data_out follows its inputs, wb_valid_out = 0, out_port = 0, retired_count = 0.

## Structure
- Shared package holds:
  - DATA_W and ADDR_W defaults.
  - Control-bit index constants CTL_REG_WRITE=0, CTL_MEM_TO_REG=1, CTL_OUT_WRITE=2, also used by the pipeline buffers and the control unit.
  - A 3-bit wb_ctl typedef.
- One sub-module, regfile_core: storage array, synchronous write, two read ports with bypass.
- The top level holds the write-back mux, out_port, retired_count and reset gating.

## Test plan
- Reset, then ctl=001, alu=0x1234, wa=5, ra1=5 in the same cycle -> read_data1=0x1234 via bypass. Next cycle with ctl=000 -> read_data1=0x1234 from the array; retired_count=1.
- ctl=011, alu=0xAAAA, mem=0x5555, wa=2 -> r2=0x5555, wb_data_out=0x5555, r2 never holds 0xAAAA.
- ctl=100, alu=0x00FF -> out_port=0x00FF next cycle, no register changes, retired_count increments. ctl=000 for 3 cycles -> no change to any state.
- Preload r3=0x0001, then rst=1 with ctl=101, alu=0xBEEF, wa=3 -> after the edge r3=0, out_port=0, retired_count=0; read_data on r3 during the reset cycle = 0x0001, with no bypass.
- Drive 65536 retiring bundles -> retired_count wraps to 0x0000. Both read ports on the same address -> identical data every cycle.
